mem_bus_master: RTL

- Initiator side of the CPU data/instruction memory bus: converts single CPU load/store requests into bus read/write transactions towards the byte-addressed RAM slaves.
- Generates the word-aligned address, byteenable and lane-replicated writedata.
- Honours waitrequest and the slave's fixed read latency, then extracts, sign-extends or zero-extends the returned lane.
- Sits between the MIPS core's memory stage and the bus interconnect.

---
 rtl/mem_bus_pkg.sv | 55 +++++
 rtl/mem_lane_extract.sv | 28 ++
 rtl/mem_bus_master.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the CPU-side memory bus master: access sizes,
// FSM states, lane enables, write-data replication and alignment checking.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_BAD  = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StLat,
        StResp
    } bus_state_e;

    function automatic logic [3:0] calc_byteenable(input mem_size_e size,
                                                   input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << addr_lo;
            SIZE_HALF: be = 4'b0011 << {addr_lo[1], 1'b0};
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    // Narrow stores are replicated across lanes; byteenable picks the live one.
    function automatic logic [31:0] calc_writedata(input mem_size_e size,
                                                   input logic [31:0] wdata);
        logic [31:0] wd;
        case (size)
            SIZE_BYTE: wd = {4{wdata[7:0]}};
            SIZE_HALF: wd = {2{wdata[15:0]}};
            default:   wd = wdata;
        endcase
        return wd;
    endfunction

    function automatic logic is_misaligned(input mem_size_e size,
                                           input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = |addr_lo;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_extract.sv
// Combinational load-lane selector: picks the addressed byte/half/word out of
// a bus word and sign- or zero-extends it to 32 bits.
module mem_lane_extract
    import mem_bus_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  mem_size_e   size,
    input  logic        sign_ext,
    output logic [31:0] ext_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        ext_data = '0;
        case (size)
            SIZE_BYTE: ext_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SIZE_HALF: ext_data = {{16{sign_ext & half_sel[15]}}, half_sel};
            SIZE_WORD: ext_data = rdata;
            default:   ext_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_bus_master.sv
// CPU load/store to byte-addressed bus master with waitrequest and fixed read latency.
// Optional waitrequest timeout is enabled by defining BUS_TIMEOUT_EN.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    bus_state_e state;
    mem_size_e  size_q;
    logic [1:0] addr_lo_q;
    logic       signed_q;
    logic [1:0] lat_cnt;
    logic [31:0] ext_data;
    mem_size_e  req_size_e;

    assign req_size_e = mem_size_e'(req_size);

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
`endif

    mem_lane_extract u_extract (
        .rdata    (readdata),
        .addr_lo  (addr_lo_q),
        .size     (size_q),
        .sign_ext (signed_q),
        .ext_data (ext_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            address    <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            writedata  <= '0;
            byteenable <= '0;
            size_q     <= SIZE_BYTE;
            addr_lo_q  <= '0;
            signed_q   <= 1'b0;
            lat_cnt    <= '0;
`ifdef BUS_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        address   <= {req_addr[31:2], 2'b00};
                        addr_lo_q <= req_addr[1:0];
                        size_q    <= req_size_e;
                        signed_q  <= req_signed;
                        if (is_misaligned(req_size_e, req_addr[1:0])) begin
                            // Rejected before any strobe is raised.
                            state     <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state      <= StBus;
                            read       <= ~req_write;
                            write      <= req_write;
                            byteenable <= calc_byteenable(req_size_e, req_addr[1:0]);
                            writedata  <= calc_writedata(req_size_e, req_wdata);
`ifdef BUS_TIMEOUT_EN
                            to_cnt     <= '0;
`endif
                        end
                    end
                end
                StBus: begin
                    if (!waitrequest) begin
                        read  <= 1'b0;
                        write <= 1'b0;
                        if (write) begin
                            state     <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= '0;
                        end else begin
                            state   <= StLat;
                            lat_cnt <= 2'(READ_LATENCY - 1);
                        end
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        read      <= 1'b0;
                        write     <= 1'b0;
                        state     <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                StLat: begin
                    // lat_cnt reaches zero on the edge where readdata is valid.
                    if (lat_cnt == 2'd0) begin
                        state     <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= ext_data;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                StResp: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= StIdle;
                end
                default: begin
                    state     <= StIdle;
                    req_ready <= 1'b1;
                    read      <= 1'b0;
                    write     <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
